freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
Parameters:
REQ-001 NCH, default 2: number of measured input channels (1..8).
REQ-002 CNT_W, default 24: per-channel edge-counter width.
REQ-003 GATE_W, default 25: gate-counter width.
REQ-004 GATE_CYCLES, default 25000000: gate window length in clk cycles; legal range 2..2^GATE_W-1.

Ports:
REQ-005 clk  in  1  single system clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request one measurement; sampled every clk.
REQ-008 cont  in  1  continuous mode; windows repeat back-to-back while high.
REQ-009 sig_in  in  NCH  asynchronous signals to measure, e.g. ring-oscillator taps.
REQ-010 busy  out  1  high in states ARM, GATE and DONE.
REQ-011 result  out  NCH*CNT_W  latched edge counts; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-012 result_valid  out  1  one-cycle pulse when result updates.
REQ-013 led  out  1  toggles once per completed window.
REQ-014 ovf  out  NCH  per-channel overflow flag; driven 0 when the feature in the Configuration section is compiled out.

Function
REQ-015 Each sig_in bit passes through a 2-flop synchroniser plus one history flop; a rising edge is detected when sync2 is 1 and hist is 0, three clk cycles after the input edge.
REQ-016 Measurable input frequency is below clk/2; faster inputs alias; this is not detected.
REQ-017 The FSM has four states: IDLE, ARM, GATE and DONE.
REQ-018 IDLE -> ARM when start is 1 or cont is 1.
REQ-019 ARM lasts 1 cycle: clears the gate counter and all channel counters, then -> GATE.
REQ-020 GATE: the gate counter increments every clk; each channel counter increments by 1 on each detected edge; -> DONE in the cycle the gate counter equals GATE_CYCLES-1; an edge detected in that cycle is counted.
REQ-021 DONE lasts 1 cycle: copies the channel counters to result, pulses result_valid and toggles led; -> ARM if cont is 1, else -> IDLE.
REQ-022 A full measurement is exactly GATE_CYCLES+2 clk cycles from ARM entry to DONE exit.
REQ-023 start while busy is ignored and is not queued.
REQ-024 cont falling mid-window: the current window completes normally, then the FSM goes to IDLE.
REQ-025 result holds its value until the next DONE; ARM does not clear result.
REQ-026 Edges during IDLE are synchronised but not counted.
REQ-027 Without the configuration feature, channel counters wrap modulo 2^CNT_W.

Reset
REQ-028 rst_n low immediately forces: FSM to IDLE, all counters to 0, synchroniser flops to 0, result to 0, result_valid to 0, led to 0, ovf to 0.
REQ-029 Reset mid-window discards the partial count; after release, no measurement starts until start or cont is seen in IDLE.

Configuration
REQ-030 Macro FREQ_METER_OVF_EN defined: each channel counter saturates at 2^CNT_W-1, and a per-channel sticky overflow bit is set on any increment attempt at saturation; the bit is cleared in ARM and copied to ovf in DONE.
REQ-031 Macro FREQ_METER_OVF_EN undefined: counters wrap per REQ-027, no overflow logic is generated, and ovf is tied to 0.

Verification (NCH=2, CNT_W=24, GATE_CYCLES=100 unless stated)
REQ-032 Scenario 1: start pulse; sig_in[0] has period 4 clk; sig_in[1]=0 -> result_valid 102 cycles after start is sampled; channel 0 reads 25 (+/-1); channel 1 reads 0; led=1.
REQ-033 Scenario 2: cont=1 held; sig_in[0] period 10 clk -> result_valid pulses every 102 cycles; each result is 10 (+/-1); led toggles on each pulse.
REQ-034 Scenario 3: start re-pulsed at cycle 50 of a window; cont=0 -> exactly one result_valid; FSM returns to IDLE; busy=0.
REQ-035 Scenario 4: CNT_W=4; 20 edges in one window -> result 4 without FREQ_METER_OVF_EN; with it, result 15 and ovf[0]=1; the next window with 3 edges gives result 3 and ovf[0]=0.
REQ-036 Scenario 5: rst_n pulsed low at GATE cycle 40 -> all outputs are 0 asynchronously and the FSM is in IDLE; a new start with period-4 input gives a clean result of 25 (+/-1).
REQ-037 Scenario 6: cont dropped at GATE cycle 60 -> that window completes with result_valid; the FSM then goes to IDLE; no further pulses.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: gated multi-channel edge counter; define FREQ_METER_OVF_EN for
// saturating counters with per-channel sticky overflow flags.
module freq_meter #(
  parameter int NCH = 2,
  parameter int CNT_W = 24,
  parameter int GATE_W = 25,
  parameter int GATE_CYCLES = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cont,
  input  logic [NCH-1:0]       sig_in,
  output logic                 busy,
  output logic [NCH*CNT_W-1:0] result,
  output logic                 result_valid,
  output logic                 led,
  output logic [NCH-1:0]       ovf
);
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  state_t state, state_nx;
  logic [NCH-1:0] s1, s2, hist, rise, full;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0] cnt [NCH];
  logic [CNT_W-1:0] res [NCH];
  assign rise = s2 & ~hist;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? ((start | cont) ? ARM : IDLE) :
               state == ARM  ? GATE :
               state == GATE ? (gate_cnt == GATE_LAST ? DONE : GATE) :
               (cont ? ARM : IDLE);
  end
  always_comb begin
    result = '0;
    for (int i = 0; i < NCH; i++) result[i*CNT_W +: CNT_W] = res[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      hist <= '0;
      gate_cnt <= '0;
      result_valid <= 1'b0;
      led <= 1'b0;
    end else begin
      state <= state_nx;
      s1 <= sig_in;
      s2 <= s1;
      hist <= s2;
      gate_cnt <= state == ARM ? '0 : state == GATE ? gate_cnt + 1'b1 : gate_cnt;
      result_valid <= state == DONE;
      led <= led ^ (state == DONE);
    end
  // A full counter only blocks increments when saturation is compiled in.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (state == ARM) cnt[i] <= '0;
        else if (state == GATE && rise[i] && !full[i]) cnt[i] <= cnt[i] + 1'b1;
        if (state == DONE) res[i] <= cnt[i];
      end
    end
`ifdef FREQ_METER_OVF_EN
  logic [NCH-1:0] sticky, ovf_r;
  assign ovf = ovf_r;
  always_comb begin
    full = '0;
    for (int i = 0; i < NCH; i++) full[i] = &cnt[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sticky <= '0;
      ovf_r <= '0;
    end else begin
      sticky <= state == ARM ? '0 : state == GATE ? sticky | (rise & full) : sticky;
      ovf_r <= state == DONE ? sticky : ovf_r;
    end
`else
  assign full = '0;
  assign ovf = '0;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized and directed checks of freq_meter against
// arithmetic expectations (edges per window = GATE_CYCLES / period).
module tb_freq_meter;
  localparam int GC = 100;
`ifdef FREQ_METER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0, sig0 = 1'b0, sig1 = 1'b0;
  logic busy0, rv0, led0, busy1, rv1, led1;
  logic [47:0] res0;
  logic [7:0] res1;
  logic [1:0] ovf0, ovf1;
  int per0 = 0, per1 = 0, left0 = -1, left1 = -1;
  int n_assert = 0, n_fail = 0;
  logic el = 1'b0;

  always #5 clk = ~clk;

  freq_meter #(.NCH(2), .CNT_W(24), .GATE_W(25), .GATE_CYCLES(GC)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .sig_in({sig1, sig0}),
    .busy(busy0), .result(res0), .result_valid(rv0), .led(led0), .ovf(ovf0));
  freq_meter #(.NCH(2), .CNT_W(4), .GATE_W(25), .GATE_CYCLES(GC)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .sig_in({sig1, sig0}),
    .busy(busy1), .result(res1), .result_valid(rv1), .led(led1), .ovf(ovf1));

  initial forever begin
    if (per0 != 0 && left0 != 0) begin
      sig0 = 1'b1;
      if (left0 > 0) left0--;
      repeat (per0 / 2) @(negedge clk);
      sig0 = 1'b0;
      repeat (per0 - per0 / 2) @(negedge clk);
    end else begin
      sig0 = 1'b0;
      @(negedge clk);
    end
  end
  initial forever begin
    if (per1 != 0 && left1 != 0) begin
      sig1 = 1'b1;
      if (left1 > 0) left1--;
      repeat (per1 / 2) @(negedge clk);
      sig1 = 1'b0;
      repeat (per1 - per1 / 2) @(negedge clk);
    end else begin
      sig1 = 1'b0;
      @(negedge clk);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic near(input string tag, input longint got, input longint exp);
    n_assert++;
    assert ((got >= exp - 1 && got <= exp + 1) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d+/-1", tag, got, exp);
    end
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!rv0 && n < max);
    if (rv0) el = ~el;
    else n = -1;
  endtask
  task automatic count_valid(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1 if (rv0) c++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_valid", rv0, 0);
    chk("rst_led", led0, 0);
    chk("rst_result", res0, 0);
    chk("rst_ovf", ovf0, 0);
    @(negedge clk) rst_n = 1'b1;

    per0 = 4;
    repeat (10) @(posedge clk);
    pulse_start();
    chk("s1_busy", busy0, 1);
    wait_valid(200, n);
    chk("s1_latency", n, 102);
    near("s1_ch0", res0[23:0], GC / 4);
    chk("s1_ch1", res0[47:24], 0);
    chk("s1_led", led0, 1);
    chk("s1_ovf", ovf0, 0);
    chk("s1_idle", busy0, 0);
    @(posedge clk);
    #1 chk("s1_pulse_len", rv0, 0);

    repeat (4) begin
      per0 = $urandom_range(4, 20);
      per1 = $urandom_range(4, 20);
      repeat (10) @(posedge clk);
      pulse_start();
      wait_valid(200, n);
      chk("rnd_latency", n, 102);
      near("rnd_ch0", res0[23:0], GC / per0);
      near("rnd_ch1", res0[47:24], GC / per1);
      chk("rnd_led", led0, el);
    end

    per0 = 10;
    per1 = 0;
    repeat (10) @(posedge clk);
    @(negedge clk) cont = 1'b1;
    wait_valid(300, n);
    chk("s2_first_seen", n > 0, 1);
    repeat (3) begin
      wait_valid(200, n);
      chk("s2_period", n, 102);
      near("s2_ch0", res0[23:0], GC / 10);
      chk("s2_led", led0, el);
    end
    repeat (60) @(posedge clk);
    #1 cont = 1'b0;
    wait_valid(200, n);
    chk("s6_last", n, 42);
    chk("s6_led", led0, el);
    count_valid(300, c);
    chk("s6_no_more", c, 0);
    chk("s6_idle", busy0, 0);

    pulse_start();
    repeat (49) @(posedge clk);
    pulse_start();
    count_valid(250, c);
    el = el ^ c[0];
    chk("s3_one_result", c, 1);
    chk("s3_idle", busy0, 0);
    chk("s3_led", led0, el);

    per0 = 0;
    per1 = 0;
    repeat (20) @(posedge clk);
    pulse_start();
    repeat (5) @(posedge clk);
    left0 = 20;
    per0 = 4;
    wait_valid(200, n);
    chk("s4_latency", n, 97);
    chk("s4_wide", res0[23:0], 20);
    chk("s4_small_valid", rv1, 1);
    chk("s4_small", res1[3:0], OVF ? 15 : 20 % 16);
    chk("s4_small_ovf", ovf1, OVF ? 1 : 0);
    chk("s4_wide_ovf", ovf0, 0);
    pulse_start();
    repeat (5) @(posedge clk);
    left0 = 3;
    wait_valid(200, n);
    chk("s4b_latency", n, 97);
    chk("s4b_small", res1[3:0], 3);
    chk("s4b_small_ovf", ovf1, 0);
    chk("s4b_wide", res0[23:0], 3);

    left0 = -1;
    per0 = 4;
    pulse_start();
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    el = 1'b0;
    chk("s5_busy", busy0, 0);
    chk("s5_valid", rv0, 0);
    chk("s5_led", led0, 0);
    chk("s5_result", res0, 0);
    chk("s5_ovf", ovf0, 0);
    chk("s5_small_result", res1, 0);
    chk("s5_small_busy", busy1, 0);
    chk("s5_small_led", led1, 0);
    @(negedge clk) rst_n = 1'b1;
    count_valid(150, c);
    chk("s5_no_restart", c, 0);
    chk("s5_still_idle", busy0, 0);
    pulse_start();
    wait_valid(200, n);
    chk("s5_latency", n, 102);
    near("s5_ch0", res0[23:0], GC / 4);
    chk("s5_led_after", led0, el);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
